// File: rtl/inst_dispatch_ctrl.sv
// inst_dispatch_ctrl
//   Instruction queue and issue scheduler between the fetcher and the decoder.
//   Buffers fetched instructions in a circular FIFO and presents at most one
//   instruction per cycle, only when the ROB and the target station (LSB for
//   loads/stores, RS otherwise) both have room. Flushes on rollback and stops
//   issuing once END_INST has issued.
//
//   Optional feature macro: INST_DISPATCH_BYPASS_EN
//     defined   -> an instruction offered while the FIFO is empty may issue in
//                  the same cycle without being stored.
//     undefined -> every instruction is stored first (1-cycle minimum latency).
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   RUN   | normal operation, head issues when resources are free
//   HALT  | END_INST has issued; no issue, pushes still accepted until full
module inst_dispatch_ctrl #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] END_INST = 32'h0ff00513
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       rollback,
  input  logic                       in_valid,
  input  logic [31:0]                in_inst,
  input  logic [31:0]                in_pc,
  input  logic                       in_is_jump,
  output logic                       in_full,
  input  logic                       rob_full,
  input  logic                       rs_full,
  input  logic                       lsb_full,
  output logic                       out_valid,
  output logic [31:0]                out_inst,
  output logic [31:0]                out_pc,
  output logic                       out_is_jump,
  output logic                       halted,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q;

  logic [31:0]     inst_mem [DEPTH];
  logic [31:0]     pc_mem   [DEPTH];
  logic [DEPTH-1:0] jump_mem;

  logic [31:0]     head_inst;
  logic [31:0]     head_pc;
  logic            head_jump;
  logic            fifo_issue;
  logic            byp_issue;
  logic            push;
  logic            pop;

  // Loads and stores go to the LSB; everything else to the RS.
  function automatic logic is_lsb_op(input logic [31:0] inst);
    return (inst[6:0] == 7'b0000011) || (inst[6:0] == 7'b0100011);
  endfunction

  function automatic logic station_full(input logic [31:0] inst,
                                        input logic lsb_f,
                                        input logic rs_f);
    return is_lsb_op(inst) ? lsb_f : rs_f;
  endfunction

  assign head_inst = inst_mem[head_q];
  assign head_pc   = pc_mem[head_q];
  assign head_jump = jump_mem[head_q];

  // full flag derives from the registered count, so a same-cycle pop never
  // makes room for a push
  assign in_full = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign halted  = (state_q == HALT);

  // Issue decisions, push/pop strobes and output muxing.
  always_comb begin
    fifo_issue = 1'b0;
    byp_issue  = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;

    fifo_issue = rdy && !rollback && (state_q == RUN) && (count_q != '0) &&
                 !rob_full && !station_full(head_inst, lsb_full, rs_full);

`ifdef INST_DISPATCH_BYPASS_EN
    byp_issue  = rdy && !rollback && (state_q == RUN) && (count_q == '0) &&
                 in_valid && !rob_full &&
                 !station_full(in_inst, lsb_full, rs_full);
`else
    byp_issue  = 1'b0;
`endif

    pop  = fifo_issue;
    push = rdy && in_valid && !rollback && !in_full && !byp_issue;
  end

  // Next state and decoder-facing outputs; outputs are zero when not issuing.
  always_comb begin
    state_d     = state_q;
    out_valid   = 1'b0;
    out_inst    = 32'h0;
    out_pc      = 32'h0;
    out_is_jump = 1'b0;

    if (byp_issue) begin
      out_valid   = 1'b1;
      out_inst    = in_inst;
      out_pc      = in_pc;
      out_is_jump = in_is_jump;
    end else if (fifo_issue) begin
      out_valid   = 1'b1;
      out_inst    = head_inst;
      out_pc      = head_pc;
      out_is_jump = head_jump;
    end

    if (rdy) begin
      if (rollback) begin
        state_d = RUN;
      end else if (out_valid && (out_inst == END_INST)) begin
        state_d = HALT;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Pointers and occupancy; rdy low freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy) begin
      if (rollback) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (pop) begin
          head_q <= head_q + PW'(1);
        end
        if (push) begin
          tail_q <= tail_q + PW'(1);
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Entry storage; contents are only meaningful between head and tail.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[tail_q] <= in_inst;
      pc_mem[tail_q]   <= in_pc;
      jump_mem[tail_q] <= in_is_jump;
    end
  end

endmodule

// File: tb/tb_inst_dispatch_ctrl.sv
// Directed self-checking bench for inst_dispatch_ctrl. Inputs change 1 time
// unit after the rising edge; combinational outputs are checked 1 unit later.
module tb_inst_dispatch_ctrl;

  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] LW   = 32'h00052283;
  localparam logic [31:0] ENDI = 32'h0ff00513;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        rollback;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        in_is_jump;
  logic        in_full;
  logic        rob_full;
  logic        rs_full;
  logic        lsb_full;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_is_jump;
  logic        halted;
  logic [3:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  inst_dispatch_ctrl #(.DEPTH(8), .END_INST(32'h0ff00513)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc),
    .in_is_jump(in_is_jump), .in_full(in_full),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .out_is_jump(out_is_jump), .halted(halted), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] inst,
                       input logic [31:0] pc, input logic j);
    in_valid   = v;
    in_inst    = inst;
    in_pc      = pc;
    in_is_jump = j;
  endtask

  task automatic test_reset();
    rst = 1'b0; rdy = 1'b1; rollback = 1'b0;
    rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    tick(); tick();
    n_cmp++; if ({in_full, out_valid, halted, count} !== 7'b0) begin n_err++; $display("FAIL reset_flags got %b want 0", {in_full, out_valid, halted, count}); end
    n_cmp++; if ({out_inst, out_pc, out_is_jump} !== 65'b0) begin n_err++; $display("FAIL reset_data got %h/%h/%b want 0", out_inst, out_pc, out_is_jump); end
    rst = 1'b1;
    tick();
    // fill 5 entries while the ROB is full, then reset mid-cycle
    rob_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      offer(1'b1, ADDI, 32'h80 + 32'(4 * i), 1'b1);
      tick();
    end
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    rob_full = 1'b0;
    #1;
    n_cmp++; if (count !== 4'd5 || out_valid !== 1'b1) begin n_err++; $display("FAIL pre_reset count=%0d valid=%b want 5/1", count, out_valid); end
    rst = 1'b0;
    #1;
    n_cmp++; if ({in_full, out_valid, halted, count, out_inst, out_pc, out_is_jump} !== 72'b0) begin n_err++; $display("FAIL async_reset valid=%b count=%0d pc=%h want all 0", out_valid, count, out_pc); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    rob_full = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(1'b1, ADDI, 32'h100 + 32'(4 * i), i[0]);
      tick();
      n_cmp++; if (count !== 4'(i + 1)) begin n_err++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); end
    end
    n_cmp++; if (in_full !== 1'b1) begin n_err++; $display("FAIL fill_in_full got %b want 1", in_full); end
    offer(1'b1, ADDI, 32'h200, 1'b0);
    tick();
    n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL ninth_dropped count got %0d want 8", count); end
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    rob_full = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(4 * i) || out_is_jump !== i[0]) begin n_err++; $display("FAIL drain[%0d] valid=%b pc=%h j=%b want 1/%h/%b", i, out_valid, out_pc, out_is_jump, 32'h100 + 32'(4 * i), i[0]); end
      tick();
      if (i == 0) begin
        n_cmp++; if (in_full !== 1'b0 || count !== 4'd7) begin n_err++; $display("FAIL unfull full=%b count=%0d want 0/7", in_full, count); end
      end
    end
    #1;
    n_cmp++; if (out_valid !== 1'b0 || count !== 4'd0 || out_pc !== 32'h0) begin n_err++; $display("FAIL drained valid=%b count=%0d pc=%h want 0/0/0", out_valid, count, out_pc); end
  endtask

  task automatic test_class_stall();
    rob_full = 1'b1;
    offer(1'b1, LW, 32'h40, 1'b0);
    tick();
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    rob_full = 1'b0; lsb_full = 1'b1; rs_full = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lsb_stall valid got %b want 0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || count !== 4'd1) begin n_err++; $display("FAIL lsb_hold valid=%b count=%0d want 0/1", out_valid, count); end
    lsb_full = 1'b0; rs_full = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_inst !== LW || out_pc !== 32'h40) begin n_err++; $display("FAIL lsb_release valid=%b inst=%h pc=%h want 1/%h/40", out_valid, out_inst, out_pc, LW); end
    tick();
    rs_full = 1'b0;
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL lsb_popped count got %0d want 0", count); end
    // an ALU op stalls on rs_full and ignores lsb_full
    rob_full = 1'b1;
    offer(1'b1, ADDI, 32'h44, 1'b0);
    tick();
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    rob_full = 1'b0; rs_full = 1'b1; lsb_full = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rs_stall valid got %b want 0", out_valid); end
    rs_full = 1'b0; lsb_full = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h44) begin n_err++; $display("FAIL rs_release valid=%b pc=%h want 1/44", out_valid, out_pc); end
    tick();
    lsb_full = 1'b0;
  endtask

  task automatic test_wrap();
`ifdef INST_DISPATCH_BYPASS_EN
    for (int k = 0; k < 20; k++) begin
      offer(1'b1, ADDI, 32'(4 * k), 1'b0);
      #1;
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || count !== 4'd0) begin n_err++; $display("FAIL wrap[%0d] valid=%b pc=%h count=%0d want 1/%h/0", k, out_valid, out_pc, count, 4 * k); end
      tick();
    end
`else
    offer(1'b1, ADDI, 32'h0, 1'b0);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL wrap_first valid got %b want 0", out_valid); end
    tick();
    for (int k = 1; k <= 20; k++) begin
      offer(k < 20, ADDI, 32'(4 * k), 1'b0);
      #1;
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * (k - 1)) || count !== 4'd1) begin n_err++; $display("FAIL wrap[%0d] valid=%b pc=%h count=%0d want 1/%h/1", k, out_valid, out_pc, count, 4 * (k - 1)); end
      tick();
    end
`endif
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (count !== 4'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL wrap_end count=%0d valid=%b want 0/0", count, out_valid); end
  endtask

  task automatic test_rollback();
    rob_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, ADDI, 32'h300 + 32'(4 * i), 1'b0);
      tick();
    end
    rob_full = 1'b0;
    rollback = 1'b1;
    offer(1'b1, ADDI, 32'h3f0, 1'b0);
    #1;
    n_cmp++; if (out_valid !== 1'b0 || count !== 4'd3) begin n_err++; $display("FAIL rb_cycle valid=%b count=%0d want 0/3", out_valid, count); end
    tick();
    rollback = 1'b0;
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (count !== 4'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL rb_flushed count=%0d valid=%b want 0/0", count, out_valid); end
    rob_full = 1'b1;
    offer(1'b1, ADDI, 32'h400, 1'b0);
    tick();
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    rob_full = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h400) begin n_err++; $display("FAIL rb_next valid=%b pc=%h want 1/400", out_valid, out_pc); end
    tick();
  endtask

  task automatic test_halt();
    rob_full = 1'b1;
    offer(1'b1, ADDI, 32'h500, 1'b0); tick();
    offer(1'b1, ENDI, 32'h504, 1'b0); tick();
    offer(1'b1, ADDI, 32'h508, 1'b0); tick();
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    rob_full = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h500 || halted !== 1'b0) begin n_err++; $display("FAIL halt_pre valid=%b pc=%h halted=%b want 1/500/0", out_valid, out_pc, halted); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_inst !== ENDI || halted !== 1'b0) begin n_err++; $display("FAIL halt_end valid=%b inst=%h halted=%b want 1/%h/0", out_valid, out_inst, halted, ENDI); end
    tick();
    n_cmp++; if (halted !== 1'b1 || out_valid !== 1'b0 || count !== 4'd1) begin n_err++; $display("FAIL halted halted=%b valid=%b count=%0d want 1/0/1", halted, out_valid, count); end
    offer(1'b1, ADDI, 32'h50c, 1'b0);
    tick();
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    n_cmp++; if (halted !== 1'b1 || out_valid !== 1'b0 || count !== 4'd2) begin n_err++; $display("FAIL halt_push halted=%b valid=%b count=%0d want 1/0/2", halted, out_valid, count); end
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    #1;
    n_cmp++; if (halted !== 1'b0 || count !== 4'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL halt_rb halted=%b count=%0d valid=%b want 0/0/0", halted, count, out_valid); end
  endtask

  task automatic test_rdy();
    rob_full = 1'b1;
    offer(1'b1, ADDI, 32'h700, 1'b0);
    tick();
    rob_full = 1'b0;
    rdy = 1'b0;
    offer(1'b1, ADDI, 32'h704, 1'b0);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rdy_low valid got %b want 0", out_valid); end
    tick();
    n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL rdy_freeze count got %0d want 1", count); end
    rdy = 1'b1;
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h700) begin n_err++; $display("FAIL rdy_resume valid=%b pc=%h want 1/700", out_valid, out_pc); end
    tick();
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL rdy_popped count got %0d want 0", count); end
  endtask

  task automatic test_bypass();
    offer(1'b1, ADDI, 32'h600, 1'b1);
    #1;
`ifdef INST_DISPATCH_BYPASS_EN
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h600 || out_is_jump !== 1'b1) begin n_err++; $display("FAIL byp_same valid=%b pc=%h j=%b want 1/600/1", out_valid, out_pc, out_is_jump); end
    tick();
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (count !== 4'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL byp_nostore count=%0d valid=%b want 0/0", count, out_valid); end
`else
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL nobyp_same valid got %b want 0", out_valid); end
    tick();
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (count !== 4'd1 || out_valid !== 1'b1 || out_pc !== 32'h600 || out_is_jump !== 1'b1) begin n_err++; $display("FAIL nobyp_next count=%0d valid=%b pc=%h want 1/1/600", count, out_valid, out_pc); end
    tick();
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL nobyp_popped count got %0d want 0", count); end
`endif
  endtask

  initial begin
    test_reset();
    test_fill();
    test_class_stall();
    test_wrap();
    test_rollback();
    test_halt();
    test_rdy();
    test_bypass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
